// File: rtl/parity_frame_sequencer.sv
// ---------------------------------------------------------------------------
// parity_frame_sequencer
//
// Takes a parallel word over a valid/ready handshake and sends it LSB-first
// on a single serial line. Each frame is a start bit (0), DATA_W data bits,
// one parity bit and a stop bit (1). Every serial bit is held for
// CLKS_PER_BIT clock cycles.
//
// Parameters:
//   DATA_W        data bits per frame (>= 1)
//   CLKS_PER_BIT  clock cycles each serial bit is held (>= 1)
//   ODD           0 = even parity, 1 = odd parity
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   data_in     word to transmit, sampled only on the accepting edge
//   valid       producer offers data_in
//   ready       high only in IDLE; a word is accepted on valid && ready
//   sout        serial line, idles high
//   busy        high in every state other than IDLE
//   done        one-cycle pulse in the first IDLE cycle after a frame
//   parity_out  parity bit of the most recently transmitted frame
// ---------------------------------------------------------------------------
module parity_frame_sequencer #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter int ODD          = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid,
    output logic              ready,
    output logic              sout,
    output logic              busy,
    output logic              done,
    output logic              parity_out
);

    // A divider of width 1 is kept even when CLKS_PER_BIT is 1; it then
    // simply stays at zero and every cycle counts as a wrap.
    localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic             ODD_BIT  = (ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]   bitcnt_q, bitcnt_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               acc_q, acc_d;
    logic               parity_q, parity_d;
    logic               done_q, done_d;
    logic               wrap;

    // Last cycle of the current bit period; all state and bit changes
    // happen only here.
    assign wrap = (div_q == DIV_MAX);

    // State register and datapath registers. Reset returns the line to idle
    // immediately and throws away any word in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            bitcnt_q <= '0;
            div_q    <= '0;
            acc_q    <= 1'b0;
            parity_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            div_q    <= div_d;
            acc_q    <= acc_d;
            parity_q <= parity_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic. The divider free-runs while a frame is active and
    // is pinned to zero in IDLE so every frame starts on a fresh period.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        div_d    = div_q;
        acc_d    = acc_q;
        parity_d = parity_q;
        done_d   = 1'b0;

        if (state_q != IDLE) begin
            div_d = wrap ? '0 : div_q + DIV_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (valid) begin
                    shift_d  = data_in;
                    acc_d    = 1'b0;
                    bitcnt_d = '0;
                    div_d    = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (wrap) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (wrap) begin
                    acc_d   = acc_q ^ shift_q[0];
                    shift_d = shift_q >> 1;
                    if (bitcnt_q == LAST_BIT) begin
                        // The last data bit folds into the parity on the same
                        // edge that enters PARITY, so use the updated value.
                        bitcnt_d = '0;
                        parity_d = acc_q ^ shift_q[0] ^ ODD_BIT;
                        state_d  = PARITY;
                    end else begin
                        bitcnt_d = bitcnt_q + CNT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (wrap) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (wrap) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Serial line is decoded from registered state only, so valid never
    // reaches sout combinationally.
    always_comb begin
        sout = 1'b1;
        case (state_q)
            START:   sout = 1'b0;
            DATA:    sout = shift_q[0];
            PARITY:  sout = acc_q ^ ODD_BIT;
            default: sout = 1'b1;
        endcase
    end

    assign ready      = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign parity_out = parity_q;

endmodule

// File: doc/parity_frame_sequencer.md
# parity_frame_sequencer

Serial frame controller that sequences the serial parity datapath. It accepts a parallel word over a valid/ready handshake and shifts it out LSB-first on a single serial line, framed as a start bit, data bits, a computed parity bit and a stop bit. Each bit is held for a programmable number of clock cycles. It sits between a word-oriented producer and any downstream serial parity consumer or checker.

## Interface
- DATA_W, 8, data bits per frame (≥1)
- CLKS_PER_BIT, 1, clock cycles each serial bit is held (≥1)
- ODD, 0, parity mode: 0 = even parity, 1 = odd parity
- clk  input  1  single clock, rising-edge
- rst  input  1  reset, asynchronous, active-high
- data_in  input  DATA_W  word to transmit; sampled only on handshake
- valid  input  1  producer offers data_in
- ready  output  1  block can accept a word; high only in IDLE
- sout  output  1  serial line; idles high
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse on frame completion
- parity_out  output  1  parity bit of the most recently transmitted frame

## Operation
- Reset values, applied asynchronously on rst: state IDLE, sout=1, ready=1, busy=0, done=0, parity_out=0. The shift register, bit counter and divider are cleared.
- States are IDLE → START → DATA → PARITY → STOP → IDLE.
- **IDLE:** sout=1 and ready=1. If valid && ready at a rising edge:
  - latch data_in into the shift register;
  - clear the parity accumulator;
  - go to START.
- **START:** sout=0 for CLKS_PER_BIT cycles.
- **DATA:** sout = shift_reg[0].
  - At the last cycle of each bit period, XOR the bit into the accumulator, shift right and increment the bit counter.
  - After DATA_W bits, go to PARITY.
- **PARITY:** sout = accumulator XOR ODD. On entry, parity_out is loaded with this value and held until the next frame's PARITY entry.
- **STOP:** sout=1 for CLKS_PER_BIT cycles, then go to IDLE with done=1 for exactly that first IDLE cycle.
- Divider counts 0..CLKS_PER_BIT-1 and wraps. State and bit transitions occur only on wrap. With CLKS_PER_BIT=1 every cycle is a wrap.
- Frame length is (DATA_W+3)·CLKS_PER_BIT cycles.
- Boundary conditions:
  - **valid or data_in changes while busy:** ignored (ready=0). The latched word is unaffected.
  - **valid held high continuously (back-to-back):** the next word is accepted in the same IDLE cycle that carries done=1. The minimum inter-frame gap is 1 cycle of sout=1.
  - **data_in all zeros or all ones:** parity follows XOR normally. Example: all ones with DATA_W even and even mode gives parity 0.
  - **rst mid-frame:** sout returns to 1 immediately and the word is discarded. No done pulse. parity_out is reset to 0.
  - **rst deassertion:** the block operates from the first rising edge after release.

## Timing
- Let E0 be the accepting edge (valid && ready sampled high).
- Start bit appears on sout in the cycle after E0. No combinational path from valid to sout.
- ready and busy are functions of registered state only; they change in the cycle after E0.
- Data bit i (LSB = bit 0) occupies cycles 1+(i+1)·CLKS_PER_BIT … (i+2)·CLKS_PER_BIT after E0.
- Parity bit occupies cycles (DATA_W+1)·CLKS_PER_BIT+1 … (DATA_W+2)·CLKS_PER_BIT.
- Stop bit occupies the next CLKS_PER_BIT cycles.
- done=1, ready=1 and busy=0 in cycle (DATA_W+3)·CLKS_PER_BIT+1 after E0.
- parity_out is updated at the edge entering PARITY and is valid in the same cycle sout carries the parity bit.

## Test plan
- **Even parity, short word.** DATA_W=6, CLKS_PER_BIT=1, ODD=0, data_in=6'b101001, one valid pulse.
  - sout in cycles 1..9 = 0,1,0,0,1,0,1,1,1 (start, 1,0,0,1,0,1, parity 1, stop).
  - parity_out=1; done pulses in cycle 10.
- **Odd parity, 8-bit word.** DATA_W=8, ODD=1, data_in=8'h69.
  - Data bits sent 1,0,0,1,0,1,1,0; parity bit 1, parity_out=1.
  - With ODD=0 the parity bit is 0.
- **Bit stretching.** CLKS_PER_BIT=4, DATA_W=8, data_in=8'hA5.
  - Each bit is held exactly 4 cycles; frame is 44 cycles.
  - done in cycle 45; busy high in cycles 1..44.
- **Back-to-back frames.** valid held high with words 8'h01 then 8'hFF.
  - Second word is accepted in the done cycle.
  - Exactly one idle-high cycle between frames; parity bits are 1 then 0 (even).
- **Busy protection.** During frame 8'h0F, change data_in to 8'hF0 and pulse valid mid-frame.
  - Transmitted bits still match 8'h0F; ready stays 0; no second frame starts.
- **Async reset mid-frame.** Assert rst during DATA bit 3, between clock edges.
  - sout=1, busy=0, ready=1, parity_out=0 immediately; no done pulse.
  - The next accepted word transmits correctly.
